// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction-fetch datapath stage. Holds PC, NPC and IR and a
//               word-organised instruction memory with a preload port.
//               Detects the halt word (32'hFFFF_FFFF) and out-of-range
//               fetches, and freezes fetch once halted.
//               Optional macro IFU_FETCH_COUNT_EN adds fetch_count and
//               branch_taken_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readim,
  input  logic              ldir,
  input  logic              ldnpc,
  input  logic              ldpc,
  input  logic              branch,
  input  logic              cond_true,
  input  logic [31:0]       aluout,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       irout,
  output logic [31:0]       npc,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              imem_err
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       branch_taken_count
`endif
);

  // Halt-word value, also returned for out-of-range fetches.
  localparam logic [31:0] c_halt_word = 32'hFFFF_FFFF;
  // Depth expressed at the widths used by the range compares.
  localparam logic [30:0]   c_depth_pc   = 31'(MEM_DEPTH);
  localparam logic [ADDR_W:0] c_depth_prog = (ADDR_W+1)'(MEM_DEPTH);

  // Run/halt state encoding.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0]       r_imem [0:MEM_DEPTH-1];
  logic [31:0]       r_pc;
  logic [31:0]       r_npc;
  logic [31:0]       r_ir;
  logic              r_imem_err;
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_halted;
  logic              w_active;
  logic              w_pc_in_range;
  logic              w_prog_in_range;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [31:0]       w_fetch_word;
  logic              w_taken;
  logic [31:0]       w_branch_tgt;
  logic              w_unused;

  // Target low bits are discarded: PC is always word aligned.
  assign w_unused = ^aluout[1:0];

  assign w_rd_idx        = r_pc[ADDR_W+1:2];
  assign w_pc_in_range   = ({1'b0, r_pc[31:2]} < c_depth_pc);
  assign w_prog_in_range = ({1'b0, prog_addr} < c_depth_prog);
  assign w_taken         = branch & cond_true;
  assign w_branch_tgt    = {aluout[31:2], 2'b00};

  // Zero-latency fetch: 0 when not reading, all-ones when beyond memory.
  always_comb begin
    w_fetch_word = 32'h0;
    if (readim) begin
      if (w_pc_in_range) begin
        w_fetch_word = r_imem[w_rd_idx];
      end else begin
        w_fetch_word = c_halt_word;
      end
    end
  end

  // Preload port; not affected by reset or halt, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (prog_we && w_prog_in_range) begin
      r_imem[prog_addr] <= prog_data;
    end
  end

  // Run/halt state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt is entered when the IR is loaded with the halt word; only reset leaves it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (ldir && (w_fetch_word == c_halt_word)) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State decode: architectural strobes only act while running.
  always_comb begin
    w_halted = (r_state == ST_HALT);
    w_active = ~w_halted;
  end

  // PC / NPC / IR update; pc takes the old npc when ldnpc and ldpc coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= {RESET_PC[31:2], 2'b00};
      r_npc <= 32'h0;
      r_ir  <= 32'h0;
    end else if (w_active) begin
      if (ldir) begin
        r_ir <= w_fetch_word;
      end
      if (ldnpc) begin
        r_npc <= r_pc + 32'd4;
      end
      if (ldpc) begin
        r_pc <= w_taken ? w_branch_tgt : r_npc;
      end
    end
  end

  // Sticky out-of-range fetch flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imem_err <= 1'b0;
    end else if (readim && !w_pc_in_range) begin
      r_imem_err <= 1'b1;
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] r_fetch_count;
  logic [15:0] r_branch_taken_count;

  // Saturating count of real fetches, including the one that loads the halt word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_active && ldir && readim && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Wrapping count of taken branches applied to the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_taken_count <= 16'h0;
    end else if (w_active && ldpc && w_taken) begin
      r_branch_taken_count <= r_branch_taken_count + 16'd1;
    end
  end

  assign fetch_count        = r_fetch_count;
  assign branch_taken_count = r_branch_taken_count;
`endif

  assign irout    = r_ir;
  assign npc      = r_npc;
  assign pc       = r_pc;
  assign halted   = w_halted;
  assign imem_err = r_imem_err;

endmodule
`default_nettype wire
